// File: rtl/booth_sequencer.sv
// Control FSM for the radix-2 Booth multiplier datapath: load, add/subtract, arithmetic shift.
// With SKIP_EN=1, runs of identical multiplier bits become a single multi-bit shift.
module booth_sequencer #(
  parameter int WIDTH   = 8,
  parameter bit SKIP_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] q_bits,
  output logic             load,
  output logic             sum_or_diff,
  output logic             shift,
  output logic [3:0]       shmnt,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] remaining, remaining_d;
  logic [CNT_W-1:0] shamt_r, shamt_d;
  logic             lsb_m, lsb_d;

  // Length of the run of bits equal to lsb starting at q[0], confined to q[rem-1:0];
  // bits above rem already hold product bits and must not extend the run.
  function automatic logic [CNT_W-1:0] run_len(
    input logic [WIDTH-1:0] q,
    input logic             lsb,
    input logic [CNT_W-1:0] rem
  );
    logic [CNT_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run && (CNT_W'(i) < rem) && (q[i] == lsb)) begin
        n = n + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  // q[n-1]: the bit that becomes the Booth LSB after a shift by n.
  function automatic logic bit_at(
    input logic [WIDTH-1:0] q,
    input logic [CNT_W-1:0] n
  );
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CNT_W'(i + 1) == n) begin
        b = q[i];
      end
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      shamt_r   <= '0;
      lsb_m     <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      shamt_r   <= shamt_d;
      lsb_m     <= lsb_d;
    end
  end

  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    shamt_d     = shamt_r;
    lsb_d       = lsb_m;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        remaining_d = CNT_W'(WIDTH);
        lsb_d       = 1'b0;
        state_d     = EVAL;
      end
      EVAL: begin
        if (!SKIP_EN || (q_bits[0] != lsb_m)) begin
          shamt_d = CNT_W'(1);
        end else begin
          shamt_d = run_len(q_bits, lsb_m, remaining);
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        // q_bits still shows the pre-shift register during this cycle.
        lsb_d       = bit_at(q_bits, shamt_r);
        remaining_d = remaining - shamt_r;
        state_d     = (remaining == shamt_r) ? DONE : EVAL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    load        = 1'b0;
    sum_or_diff = 1'b0;
    shift       = 1'b0;
    shmnt       = 4'd0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      EVAL: begin
        busy        = 1'b1;
        sum_or_diff = !SKIP_EN || (q_bits[0] != lsb_m);
      end
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        shmnt = 4'(shamt_r);
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  a_shift_bounded: assert property (@(posedge clk) disable iff (rst)
    (state == SHIFT) |-> ((shamt_r != '0) && (shamt_r <= remaining)));

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({load, sum_or_diff, shift}));

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed bench: classic and run-skipping sequencers, each driving a behavioural Booth datapath.
module tb_booth_sequencer;

  localparam int MAXC = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1;
  logic [7:0]  in1_0, in2_0, in1_1, in2_1;
  logic [16:0] aqq0, aqq1;
  logic [7:0]  m0, m1;

  logic       load0, sd0, sh0, busy0, done0;
  logic [3:0] shmnt0;
  logic       load1, sd1, sh1, busy1, done1;
  logic [3:0] shmnt1;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  tr [0:63];
  int          done_cyc;
  logic [15:0] prod;

  booth_sequencer #(.WIDTH(8), .SKIP_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .q_bits(aqq0[8:1]),
    .load(load0), .sum_or_diff(sd0), .shift(sh0), .shmnt(shmnt0),
    .busy(busy0), .done(done0)
  );

  booth_sequencer #(.WIDTH(8), .SKIP_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .q_bits(aqq1[8:1]),
    .load(load1), .sum_or_diff(sd1), .shift(sh1), .shmnt(shmnt1),
    .busy(busy1), .done(done1)
  );

  // Datapath model: state is {A, Q, Q-1}; shift is arithmetic across all 17 bits.
  function automatic logic [16:0] dp_step(input logic [16:0] s, input logic [7:0] m,
                                          input logic ld, input logic sd, input logic sh,
                                          input logic [3:0] n, input logic [7:0] b);
    logic [16:0] r;
    r = s;
    if (ld) r = {8'h00, b, 1'b0};
    else if (sd) begin
      if (s[1:0] == 2'b10) r[16:9] = s[16:9] - m;
      else if (s[1:0] == 2'b01) r[16:9] = s[16:9] + m;
    end else if (sh) r = 17'($signed(s) >>> n);
    return r;
  endfunction

  always @(posedge clk) begin
    aqq0 <= dp_step(aqq0, m0, load0, sd0, sh0, shmnt0, in2_0);
    aqq1 <= dp_step(aqq1, m1, load1, sd1, sh1, shmnt1, in2_1);
    if (load0) m0 <= in1_0;
    if (load1) m1 <= in1_1;
  end

  function automatic logic [8:0] obs(input int inst);
    if (inst == 0) return {load0, sd0, sh0, busy0, done0, shmnt0};
    return {load1, sd1, sh1, busy1, done1, shmnt1};
  endfunction

  function automatic logic [8:0] v(input logic l, input logic s, input logic h,
                                   input logic b, input logic d, input int n);
    return {l, s, h, b, d, 4'(n)};
  endfunction

  // Drives one start pulse from IDLE and records outputs per cycle until done (bounded).
  task automatic run_op(input int inst, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 64; i++) tr[i] = 9'h1FF;
    @(posedge clk); #1;
    if (inst == 0) begin in1_0 = a; in2_0 = b; start0 = 1'b1; end
    else begin in1_1 = a; in2_1 = b; start1 = 1'b1; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    done_cyc = -1;
    prod = 16'h0000;
    for (int c = 1; c <= MAXC; c++) begin
      tr[c] = obs(inst);
      if (tr[c][4]) begin
        done_cyc = c;
        prod = (inst == 0) ? aqq0[16:1] : aqq1[16:1];
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    in1_0 = '0; in2_0 = '0; in1_1 = '0; in2_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 9'h000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h expected 000", i, obs(i));
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 9'h000) begin
        errors++;
        $display("FAIL idle_after_reset dut%0d: got %h expected 000", i, obs(i));
      end
    end
  endtask

  task automatic test_classic(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [15:0] exp_prod);
    logic [8:0] e;
    bit h;
    run_op(0, a, b);
    checks++;
    if (done_cyc != 18) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected 18", name, done_cyc);
    end
    for (int c = 1; c <= 18; c++) begin
      h = (c >= 3) && (c <= 17) && (c % 2 == 1);
      e = v(c == 1, (c >= 2) && (c <= 16) && (c % 2 == 0), h, c <= 17, c == 18, h ? 1 : 0);
      checks++;
      if (tr[c] !== e) begin
        errors++;
        $display("FAIL %s_cycle%0d: got %h expected %h", name, c, tr[c], e);
      end
    end
    checks++;
    if (prod !== exp_prod) begin
      errors++;
      $display("FAIL %s_product: got %h expected %h", name, prod, exp_prod);
    end
  endtask

  task automatic test_skip_zero();
    logic [8:0] et [1:4];
    et[1] = v(1, 0, 0, 1, 0, 0); et[2] = v(0, 0, 0, 1, 0, 0);
    et[3] = v(0, 0, 1, 1, 0, 8); et[4] = v(0, 0, 0, 0, 1, 0);
    run_op(1, 8'h25, 8'h00);
    checks++;
    if (done_cyc != 4) begin errors++; $display("FAIL skip_zero_latency: got %0d expected 4", done_cyc); end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (tr[c] !== et[c]) begin
        errors++; $display("FAIL skip_zero_cycle%0d: got %h expected %h", c, tr[c], et[c]);
      end
    end
    checks++;
    if (prod !== 16'h0000) begin errors++; $display("FAIL skip_zero_product: got %h expected 0000", prod); end
  endtask

  task automatic test_skip_ones();
    logic [8:0] et [1:6];
    et[1] = v(1, 0, 0, 1, 0, 0); et[2] = v(0, 1, 0, 1, 0, 0); et[3] = v(0, 0, 1, 1, 0, 1);
    et[4] = v(0, 0, 0, 1, 0, 0); et[5] = v(0, 0, 1, 1, 0, 7); et[6] = v(0, 0, 0, 0, 1, 0);
    run_op(1, 8'h07, 8'hFF);
    checks++;
    if (done_cyc != 6) begin errors++; $display("FAIL skip_ones_latency: got %0d expected 6", done_cyc); end
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (tr[c] !== et[c]) begin
        errors++; $display("FAIL skip_ones_cycle%0d: got %h expected %h", c, tr[c], et[c]);
      end
    end
    checks++;
    if (prod !== 16'hFFF9) begin errors++; $display("FAIL skip_ones_product: got %h expected fff9", prod); end
  endtask

  // Multiplier 0x30: zero run bounded by the remaining count, mixed runs after it.
  task automatic test_skip_mixed();
    logic [8:0] et [1:12];
    int sum;
    et[1]  = v(1, 0, 0, 1, 0, 0); et[2]  = v(0, 0, 0, 1, 0, 0); et[3]  = v(0, 0, 1, 1, 0, 4);
    et[4]  = v(0, 1, 0, 1, 0, 0); et[5]  = v(0, 0, 1, 1, 0, 1); et[6]  = v(0, 0, 0, 1, 0, 0);
    et[7]  = v(0, 0, 1, 1, 0, 1); et[8]  = v(0, 1, 0, 1, 0, 0); et[9]  = v(0, 0, 1, 1, 0, 1);
    et[10] = v(0, 0, 0, 1, 0, 0); et[11] = v(0, 0, 1, 1, 0, 1); et[12] = v(0, 0, 0, 0, 1, 0);
    run_op(1, 8'h03, 8'h30);
    checks++;
    if (done_cyc != 12) begin errors++; $display("FAIL skip_mixed_latency: got %0d expected 12", done_cyc); end
    sum = 0;
    for (int c = 1; c <= 12; c++) begin
      if (tr[c] != 9'h1FF) sum += int'(tr[c][3:0]);
      checks++;
      if (tr[c] !== et[c]) begin
        errors++; $display("FAIL skip_mixed_cycle%0d: got %h expected %h", c, tr[c], et[c]);
      end
    end
    checks++;
    if (sum != 8) begin errors++; $display("FAIL skip_mixed_shmnt_sum: got %0d expected 8", sum); end
    checks++;
    if (prod !== 16'h0090) begin errors++; $display("FAIL skip_mixed_product: got %h expected 0090", prod); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    in1_0 = 8'd5; in2_0 = 8'd3; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (!busy0) begin errors++; $display("FAIL reset_mid_busy_cycle5: got %b expected 1", busy0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (obs(0) !== 9'h000) begin errors++; $display("FAIL reset_mid_outputs: got %h expected 000", obs(0)); end
    @(posedge clk); #1;
    checks++;
    if (obs(0) !== 9'h000) begin errors++; $display("FAIL reset_mid_stays_idle: got %h expected 000", obs(0)); end
    run_op(0, 8'd5, 8'd3);
    checks++;
    if (done_cyc != 18) begin errors++; $display("FAIL reset_mid_rerun_latency: got %0d expected 18", done_cyc); end
    checks++;
    if (prod !== 16'h000F) begin errors++; $display("FAIL reset_mid_rerun_product: got %h expected 000f", prod); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] o;
    int loads, dc;
    // Run-skipping instance, zero multiplier, start held through DONE.
    @(posedge clk); #1;
    in1_1 = 8'h11; in2_1 = 8'h00; start1 = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      o = obs(1);
      checks++;
      if (o[8] !== ((c == 1) || (c == 6))) begin
        errors++; $display("FAIL held_start_load_cycle%0d: got %b expected %b", c, o[8], (c == 1) || (c == 6));
      end
      checks++;
      if (o[4] !== ((c == 4) || (c == 9))) begin
        errors++; $display("FAIL held_start_done_cycle%0d: got %b expected %b", c, o[4], (c == 4) || (c == 9));
      end
      if (c == 5) begin
        checks++;
        if (o !== 9'h000) begin errors++; $display("FAIL held_start_idle_gap: got %h expected 000", o); end
      end
      if (c == 6) start1 = 1'b0;
      @(posedge clk); #1;
    end
    // Classic instance, stray start pulses while busy and in DONE.
    @(posedge clk); #1;
    in1_0 = 8'd5; in2_0 = 8'd3; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    loads = 0; dc = -1;
    for (int c = 1; c <= 22; c++) begin
      if (load0) loads++;
      if (done0 && dc < 0) begin dc = c; prod = aqq0[16:1]; end
      start0 = (c == 5) || (c == 10) || (c == 18);
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    checks++;
    if (loads != 1) begin errors++; $display("FAIL stray_start_loads: got %0d expected 1", loads); end
    checks++;
    if (dc != 18) begin errors++; $display("FAIL stray_start_latency: got %0d expected 18", dc); end
    checks++;
    if (prod !== 16'h000F) begin errors++; $display("FAIL stray_start_product: got %h expected 000f", prod); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_classic("classic_5x3", 8'd5, 8'd3, 16'h000F);
    test_classic("classic_m3x5", 8'hFD, 8'd5, 16'hFFF1);
    test_skip_zero();
    test_skip_ones();
    test_skip_mixed();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_sequencer.md
Name: booth_sequencer

Overview:
- Control FSM that sequences the 8-bit radix-2 Booth multiplier datapath (`data_path`) through its load, add/subtract and arithmetic-shift steps.
- Drives the datapath's `load`, `sum_or_diff`, `shift` and `shmnt` inputs, and watches the multiplier register (`dxb_input_2`) to track the Booth LSB.
- Optional run-skipping mode: runs of identical multiplier bits are collapsed into one multi-bit shift, cutting latency.
- Provides a start/busy/done handshake to the surrounding system.

Parameters:
- WIDTH, 8, operand width. Fixed to match `data_path`; sizes the iteration counter.
- SKIP_EN, 0, 0 = classic one-bit-per-iteration Booth; 1 = run-skipping mode with variable `shmnt`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiplication. Sampled only in IDLE; the operands must already be on the datapath inputs `input_1`/`input_2`.
- q_bits  input  WIDTH  current value of datapath `dxb_input_2` (the multiplier/Q register).
- load  output  1  datapath load strobe.
- sum_or_diff  output  1  datapath add/subtract strobe.
- shift  output  1  datapath arithmetic-shift strobe.
- shmnt  output  4  shift amount, valid while `shift`=1; 0 otherwise.
- busy  output  1  high from the LOAD state through the last SHIFT state.
- done  output  1  one-cycle pulse: the product is complete in the datapath `{dxb_input_1, dxb_input_2}`.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, remaining=0, lsb_m=0, shamt_r=0.
  - All outputs 0. Applies mid-operation too; a partial datapath result is abandoned.
- States: IDLE, LOAD, EVAL, SHIFT, DONE. Strobe outputs are decoded from the registered state, so load/sum_or_diff/shift are always mutually exclusive (one-hot or all zero).
- IDLE:
  - All strobes 0, busy=0.
  - If start=1: go to LOAD. Otherwise stay.
- LOAD:
  - load=1, busy=1.
  - Next-state registers: remaining<=WIDTH, lsb_m<=0 (mirrors the datapath LSB clear).
  - Go to EVAL.
- EVAL (q_bits now reflects the datapath Q register):
  - SKIP_EN=0:
    - sum_or_diff=1 unconditionally; the datapath itself no-ops on 00/11.
    - shamt_r<=1, go to SHIFT.
  - SKIP_EN=1, q_bits[0]!=lsb_m:
    - sum_or_diff=1, shamt_r<=1, go to SHIFT.
  - SKIP_EN=1, q_bits[0]==lsb_m:
    - No strobe this cycle.
    - r = count of consecutive bits from q_bits[0] upward equal to lsb_m, counting only within q_bits[remaining-1:0]. Upper Q bits hold product bits and must be ignored.
    - shamt_r<=min(r, remaining), which is always >=1. Go to SHIFT.
- SHIFT:
  - shift=1, shmnt=shamt_r.
  - Updates: lsb_m<=q_bits[shamt_r-1] (pre-shift value), remaining<=remaining-shamt_r.
  - If remaining-shamt_r==0: go to DONE. Otherwise go to EVAL.
- DONE:
  - done=1, busy=0. Go to IDLE.
- start is ignored in every state except IDLE, including DONE. A start held high re-triggers in the IDLE cycle after DONE.
- Latency, counted from the start-sampling edge (LOAD is cycle 1):
  - SKIP_EN=0: done is high in cycle 2*WIDTH+2 = 18.
  - SKIP_EN=1: done is high in cycle 2+2k, where k = number of SHIFT visits. Minimum is cycle 4 (multiplier 0), maximum is cycle 18.
- Invariants:
  - remaining never underflows.
  - shmnt never exceeds remaining and is never 0 while shift=1.
  - The sum of all shmnt values in one operation equals WIDTH.

Test Plan:
- SKIP_EN=0, input_1=5, input_2=3, start pulse:
  - load in cycle 1; sum_or_diff/shift alternate with shmnt=1 eight times; done in cycle 18.
  - Datapath {A,Q}=16'h000F.
- SKIP_EN=0, input_1=-3 (8'hFD), input_2=5 → done in cycle 18, {A,Q}=16'hFFF1 (-15).
- SKIP_EN=1, input_2=8'h00 → one EVAL with no strobe, then shift with shmnt=8; done in cycle 4; product 0.
- SKIP_EN=1, input_1=7, input_2=8'hFF:
  - Sequence: EVAL sum_or_diff, SHIFT shmnt=1, EVAL (no strobe), SHIFT shmnt=7; done in cycle 6.
  - {A,Q}=16'hFFF9 (-7).
- rst asserted in cycle 5 of an operation → next cycle all outputs 0 and state IDLE. A new start then completes correctly: 5*3=15.
- start held high through DONE → IDLE for one cycle, then LOAD; start pulses during busy cause no extra load.
